// File: rtl/group_max_forward_pkg.sv
// Shared types for group_max_forward: the per-stage record and the most-negative helper.
// The record widths follow the package defaults; the top's parameters default to the same values.
package group_max_forward_pkg;

  localparam int GMF_DATA_W = 16;
  localparam int GMF_PAY_W  = 16;
  localparam int GMF_LEN_W  = 4;

  function automatic logic [63:0] most_neg(input int unsigned width);
    logic [63:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

  typedef struct packed {
    logic                         valid;
    logic                         gid;
    logic signed [GMF_DATA_W-1:0] gmax;
    logic [GMF_LEN_W-1:0]         len;
    logic [GMF_PAY_W-1:0]         pay;
    logic                         last;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{
    valid: 1'b0,
    gid:   1'b0,
    gmax:  GMF_DATA_W'(most_neg(GMF_DATA_W)),
    len:   '0,
    pay:   '0,
    last:  1'b0
  };

endpackage

// File: rtl/group_max_acc.sv
// Running signed maximum of the open group; front includes the beat on the input this cycle.
module group_max_acc
  import group_max_forward_pkg::*;
#(
  parameter int DATA_W = GMF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] loc_max,
  output logic signed [DATA_W-1:0] front
);

  localparam logic signed [DATA_W-1:0] MOST_NEG = DATA_W'(most_neg(DATA_W));

  logic signed [DATA_W-1:0] acc_q, acc_d;

  // The last beat restarts the accumulator so the next group can begin on the very next beat.
  always_comb begin
    front = (loc_max > acc_q) ? loc_max : acc_q;
    acc_d = acc_q;
    if (upd) begin
      acc_d = clr ? MOST_NEG : front;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= MOST_NEG;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/group_max_forward.sv
// Delay line that rewrites every in-flight beat of a group with the group maximum once its
// last beat arrives; the beat leaving the output that same cycle gets the maximum forwarded.
module group_max_forward
  import group_max_forward_pkg::*;
#(
  parameter int DATA_W = GMF_DATA_W,
  parameter int PAY_W  = GMF_PAY_W,
  parameter int DEPTH  = 12,
  parameter int LEN_W  = GMF_LEN_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_loc_max,
  input  logic [LEN_W-1:0]         i_len,
  input  logic [PAY_W-1:0]         i_pay,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] o_max,
  output logic [LEN_W-1:0]         o_len,
  output logic [PAY_W-1:0]         o_pay,
  output logic                     o_last,
  output logic                     o_err
);

  stage_t stage_q [DEPTH];
  stage_t stage_d [DEPTH];

  logic [LEN_W-1:0]         cnt_q, cnt_d, len_q, len_d, cur_len;
  logic                     gid_q, gid_d, err_q, err_d;
  logic                     accept, first, last, close_grp, fwd_out, seen_last;
  logic [DEPTH-1:0]         open;
  logic signed [DATA_W-1:0] front;

  assign accept    = i_en & i_valid;
  assign first     = (cnt_q == '0);
  assign close_grp = accept & last;

  group_max_acc #(.DATA_W(DATA_W)) u_acc (
    .clk     (i_clk),
    .rst     (i_rst),
    .upd     (accept),
    .clr     (last),
    .loc_max (i_loc_max),
    .front   (front)
  );

  // A stage is "open" when it holds a beat of the unfinished group: no last beat sits between it
  // and the input. This keeps a group two back with the same id bit from being rewritten.
  always_comb begin
    cur_len   = first ? i_len : len_q;
    last      = (cur_len <= LEN_W'(1)) || (cnt_q == cur_len - LEN_W'(1));
    cnt_d     = cnt_q;
    len_d     = len_q;
    gid_d     = gid_q;
    open      = '0;
    seen_last = 1'b0;
    if (accept) begin
      cnt_d = last ? '0 : cnt_q + LEN_W'(1);
      if (first) begin
        len_d = i_len;
        gid_d = ~gid_q;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      open[k]   = stage_q[k].valid && !stage_q[k].last && !seen_last && (stage_q[k].gid == gid_q);
      seen_last = seen_last | (stage_q[k].valid & stage_q[k].last);
    end
    fwd_out = close_grp && open[DEPTH-1];
    err_d   = err_q | (i_en && open[DEPTH-1] && !close_grp);
  end

  always_comb begin
    stage_d = stage_q;
    if (i_en) begin
      stage_d[0] = STAGE_IDLE;
      if (accept) begin
        stage_d[0].valid = 1'b1;
        stage_d[0].gid   = gid_d;
        stage_d[0].gmax  = last ? front : i_loc_max;
        stage_d[0].len   = cur_len;
        stage_d[0].pay   = i_pay;
        stage_d[0].last  = last;
      end
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
        if (close_grp && open[k-1]) begin
          stage_d[k].gmax = front;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= STAGE_IDLE;
      end
      cnt_q <= '0;
      len_q <= '0;
      gid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gid_q   <= gid_d;
      err_q   <= err_d;
    end
  end

  assign o_valid = stage_q[DEPTH-1].valid;
  assign o_max   = fwd_out ? front : stage_q[DEPTH-1].gmax;
  assign o_len   = stage_q[DEPTH-1].len;
  assign o_pay   = stage_q[DEPTH-1].pay;
  assign o_last  = stage_q[DEPTH-1].last;
  assign o_err   = err_q;

endmodule

// File: tb/tb_group_max_forward.sv
// Self-checking bench for group_max_forward: a group-level reference model checked every
// cycle, directed scenarios with literal expectations, and randomized traffic.
module tb_group_max_forward;

  localparam int DATA_W = 16;
  localparam int PAY_W  = 16;
  localparam int DEPTH  = 12;
  localparam int LEN_W  = 4;
  localparam int HMAX   = 8192;

  logic                     i_clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic                     i_en = 1'b0;
  logic                     i_valid = 1'b0;
  logic signed [DATA_W-1:0] i_loc_max = '0;
  logic [LEN_W-1:0]         i_len = '0;
  logic [PAY_W-1:0]         i_pay = '0;
  logic                     o_valid;
  logic signed [DATA_W-1:0] o_max;
  logic [LEN_W-1:0]         o_len;
  logic [PAY_W-1:0]         o_pay;
  logic                     o_last;
  logic                     o_err;

  always #5 i_clk = ~i_clk;

  group_max_forward #(
    .DATA_W (DATA_W),
    .PAY_W  (PAY_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_valid   (i_valid),
    .i_loc_max (i_loc_max),
    .i_len     (i_len),
    .i_pay     (i_pay),
    .o_valid   (o_valid),
    .o_max     (o_max),
    .o_len     (o_len),
    .o_pay     (o_pay),
    .o_last    (o_last),
    .o_err     (o_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: history of accepted beats per enabled cycle plus per-group results.
  typedef struct {
    bit valid;
    int grp;
    int own;
    int len;
    int pay;
    bit last;
  } rec_t;

  rec_t hist [HMAX];
  int   g_max [HMAX];
  int   g_len [HMAX];
  bit   g_closed [HMAX];
  int   t_m, grp_m, cnt_m, run_m, cyc;
  bit   in_grp_m, err_m, last_m;
  rec_t cur_r;
  int   exp_max;

  int cap_max[$];
  int cap_last[$];
  int cap_cyc[$];

  task automatic modelReset();
    t_m = 0;
    grp_m = -1;
    cnt_m = 0;
    run_m = 0;
    in_grp_m = 1'b0;
    err_m = 1'b0;
  endtask

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      modelReset();
      checkOutput("reset_valid", o_valid, 0);
      checkOutput("reset_err", o_err, 0);
    end else begin
      checkOutput("err", o_err, err_m);
      if (i_en) begin
        hist[t_m].valid = i_valid;
        hist[t_m].last = 1'b0;
        if (i_valid) begin
          if (!in_grp_m) begin
            grp_m++;
            in_grp_m = 1'b1;
            cnt_m = 0;
            run_m = i_loc_max;
            g_len[grp_m] = i_len;
            g_closed[grp_m] = 1'b0;
          end else if (i_loc_max > run_m) begin
            run_m = i_loc_max;
          end
          cnt_m++;
          last_m = (g_len[grp_m] <= 1) || (cnt_m == g_len[grp_m]);
          if (last_m) begin
            g_max[grp_m] = run_m;
            g_closed[grp_m] = 1'b1;
            in_grp_m = 1'b0;
          end
          hist[t_m].grp = grp_m;
          hist[t_m].own = i_loc_max;
          hist[t_m].len = g_len[grp_m];
          hist[t_m].pay = i_pay;
          hist[t_m].last = last_m;
        end
        cur_r.valid = 1'b0;
        if (t_m >= DEPTH) cur_r = hist[t_m-DEPTH];
        checkOutput("valid", o_valid, cur_r.valid);
        if (cur_r.valid) begin
          exp_max = g_closed[cur_r.grp] ? g_max[cur_r.grp] : cur_r.own;
          if (!g_closed[cur_r.grp]) err_m = 1'b1;
          checkOutput("max", o_max, exp_max);
          checkOutput("len", o_len, cur_r.len);
          checkOutput("pay", o_pay, cur_r.pay);
          checkOutput("last", o_last, cur_r.last);
          cap_max.push_back(int'(o_max));
          cap_last.push_back(int'(o_last));
          cap_cyc.push_back(cyc);
        end
        t_m++;
      end
    end
  end

  task automatic applyStimulus(input bit en, input bit vld, input int mx, input int len,
                               input int pay);
    i_en = en;
    i_valid = vld;
    i_loc_max = DATA_W'(mx);
    i_len = LEN_W'(len);
    i_pay = PAY_W'(pay);
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    i_rst = 1'b0;
    cap_max.delete();
    cap_last.delete();
    cap_cyc.delete();
  endtask

  task automatic flush();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1, 0, 0, 0, 0);
  endtask

  int vals[$];
  int ref_max[$];
  int ref_delta, stall_delta, start_cyc, len_r;

  initial begin
    doReset();

    // Three-beat group: every beat leaves with the group max, last flag on the third.
    vals = '{5, -2, 9};
    foreach (vals[i]) applyStimulus(1, 1, vals[i], 3, 100 + i);
    flush();
    checkOutput("g3_count", cap_max.size(), 3);
    for (int i = 0; i < 3; i++) checkOutput("g3_max", cap_max[i], 9);
    checkOutput("g3_last0", cap_last[0], 0);
    checkOutput("g3_last2", cap_last[2], 1);

    // Longest group that still completes before its first beat leaves.
    doReset();
    for (int i = 0; i < 13; i++) applyStimulus(1, 1, i, 13, i);
    flush();
    checkOutput("g13_count", cap_max.size(), 13);
    checkOutput("g13_first", cap_max[0], 12);
    checkOutput("g13_mid", cap_max[6], 12);
    checkOutput("g13_err", o_err, 0);

    // Bubbles inside a group.
    doReset();
    applyStimulus(1, 1, 1, 4, 1);
    applyStimulus(1, 0, 50, 0, 0);
    applyStimulus(1, 1, 7, 0, 2);
    applyStimulus(1, 0, 60, 0, 0);
    applyStimulus(1, 1, 3, 0, 3);
    applyStimulus(1, 1, 2, 0, 4);
    flush();
    checkOutput("bub_count", cap_max.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("bub_max", cap_max[i], 7);

    // Back-to-back groups of differing lengths.
    doReset();
    applyStimulus(1, 1, -5, 2, 1);
    applyStimulus(1, 1, -9, 0, 2);
    applyStimulus(1, 1, -100, 1, 3);
    flush();
    checkOutput("b2b_count", cap_max.size(), 3);
    checkOutput("b2b_max0", cap_max[0], -5);
    checkOutput("b2b_max1", cap_max[1], -5);
    checkOutput("b2b_max2", cap_max[2], -100);

    // Over-long group: early beats leave with their own value, error sticks until reset.
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(1, 1, 3 * i, 15, i);
    flush();
    checkOutput("long_max0", cap_max[0], 0);
    checkOutput("long_max1", cap_max[1], 3);
    checkOutput("long_max2", cap_max[2], 42);
    checkOutput("long_err", o_err, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("long_err_held", o_err, 1);
    i_rst = 1'b1;
    #1;
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_max", o_max, -32768);
    checkOutput("rst_len", o_len, 0);
    checkOutput("rst_pay", o_pay, 0);
    checkOutput("rst_last", o_last, 0);

    // Stall mid-group must only delay the outputs.
    doReset();
    vals = '{4, -1, 8, 2, 6};
    start_cyc = cyc;
    foreach (vals[i]) applyStimulus(1, 1, vals[i], 5, i);
    flush();
    ref_max = cap_max;
    ref_delta = cap_cyc[0] - start_cyc;
    checkOutput("stall_ref_delta", ref_delta, DEPTH + 1);
    doReset();
    start_cyc = cyc;
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, vals[i], 5, i);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 99, 2, 77);
    for (int i = 3; i < 5; i++) applyStimulus(1, 1, vals[i], 5, i);
    flush();
    stall_delta = cap_cyc[0] - start_cyc;
    checkOutput("stall_shift", stall_delta - ref_delta, 3);
    checkOutput("stall_count", cap_max.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_same", cap_max[i], ref_max[i]);
      checkOutput("stall_max", cap_max[i], 8);
    end

    // Randomized traffic, with a reset (usually mid-group) before each epoch.
    for (int ep = 0; ep < 4; ep++) begin
      doReset();
      for (int c = 0; c < 700; c++) begin
        len_r = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13);
        applyStimulus($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 75,
                      $urandom_range(0, 65535) - 32768, len_r, $urandom_range(0, 65535));
      end
    end
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
